// File: rtl/axi_word_writer.sv
// Drains a first-word-fall-through word FIFO and writes each word to DDR as a
// single-beat AXI4 INCR write, walking a ring buffer that starts at BASE_ADDR.
module axi_word_writer #(
    parameter int unsigned            WORD_WIDTH   = 256,
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned            REGION_BYTES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    input  logic [WORD_WIDTH-1:0]     fifo_dout,
    output logic                      fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [WORD_WIDTH-1:0]     m_axi_wdata,
    output logic [WORD_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic                      busy,
    output logic                      wr_err,
    output logic [31:0]               words_written
);

    localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
    localparam int unsigned OFF_W      = (REGION_BYTES > 1) ? $clog2(REGION_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pop;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             addr_data_done;
    logic [OFF_W-1:0] offset;
    logic [OFF_W:0]   offset_inc;
    logic             offset_wrap;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = (state == RESP) & m_axi_bvalid & m_axi_bready;

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign addr_data_done = (aw_hs | ~m_axi_awvalid) & (w_hs | ~m_axi_wvalid);

    // One extra bit so the increment can reach REGION_BYTES before wrapping.
    assign offset_inc  = {1'b0, offset} + (OFF_W+1)'(WORD_BYTES);
    assign offset_wrap = (offset_inc == (OFF_W+1)'(REGION_BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                if (addr_data_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_wdata   <= '0;
            wr_err        <= 1'b0;
            words_written <= '0;
            offset        <= '0;
        end else begin
            if (pop) begin
                m_axi_wdata   <= fifo_dout;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
            end
            if (aw_hs) begin
                m_axi_awvalid <= 1'b0;
            end
            if (w_hs) begin
                m_axi_wvalid <= 1'b0;
            end
            if (state == ADDR_DATA && addr_data_done) begin
                m_axi_bready <= 1'b1;
            end
            if (b_hs) begin
                m_axi_bready  <= 1'b0;
                words_written <= words_written + 32'd1;
                if (m_axi_bresp != 2'b00) begin
                    wr_err <= 1'b1;
                end
                offset <= offset_wrap ? '0 : offset_inc[OFF_W-1:0];
            end
        end
    end

    // The pop is gated by rst so a held reset never drains the FIFO.
    assign fifo_rd_en    = pop & ~rst;
    assign m_axi_awaddr  = BASE_ADDR + ADDR_WIDTH'(offset);
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'($clog2(WORD_BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_axi_word_writer.sv
// Directed bench for axi_word_writer: 256-bit words in a 64-byte ring at 0x1000_0000,
// with a small FWFT FIFO model and per-feature check tasks.
module tb_axi_word_writer;

    localparam int unsigned          WW   = 256;
    localparam int unsigned          AW   = 32;
    localparam logic [31:0]          BASE = 32'h1000_0000;
    localparam int unsigned          RB   = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            fifo_empty;
    logic [WW-1:0]   fifo_dout;
    logic            fifo_rd_en;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [WW-1:0]   m_axi_wdata;
    logic [WW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic            busy;
    logic            wr_err;
    logic [31:0]     words_written;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    logic [WW-1:0] q[$];

    axi_word_writer #(
        .WORD_WIDTH  (WW),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .REGION_BYTES(RB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .busy         (busy),
        .wr_err       (wr_err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [WW-1:0] w);
        q.push_back(w);
        refresh();
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        logic popped;
        #1;
        popped = fifo_rd_en;
        if (popped) rd_cnt++;
        @(posedge clk);
        #1;
        if (popped && q.size() != 0) void'(q.pop_front());
        refresh();
    endtask

    task automatic test_reset();
        logic [WW/8-1:0] ones;
        ones = '1;
        rst = 1'b1;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        push({32{8'h3C}});
        tick();
        tick();
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL reset_rd_en: pulses=%0d required=0", rd_cnt); end
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, wr_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: aw/w/b/busy/err=%b required=00000",
                               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, wr_err}); end
        checks++; if (words_written !== 32'd0) begin errors++; $display("FAIL reset_count: got=%0d required=0", words_written); end
        checks++; if (m_axi_awaddr !== BASE) begin errors++; $display("FAIL reset_awaddr: got=%h required=%h", m_axi_awaddr, BASE); end
        checks++; if (m_axi_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got=%h required=0", m_axi_wdata); end
        checks++; if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast} !== {8'd0, 3'd5, 2'b01, 1'b0}) begin
            errors++; $display("FAIL reset_consts: len=%0d size=%0d burst=%b wlast=%b required 0/5/01/0",
                               m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast); end
        checks++; if (m_axi_wstrb !== ones) begin errors++; $display("FAIL reset_wstrb: got=%h required all ones", m_axi_wstrb); end
        q.delete();
        refresh();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [WW-1:0] exp_w;
        int rd0;
        exp_w = {32{8'hA5}};
        rd0 = rd_cnt;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        push(exp_w);
        tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, busy} !== 4'b1111) begin
            errors++; $display("FAIL single_valids: aw/w/last/busy=%b required=1111",
                               {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, busy}); end
        checks++; if (m_axi_awaddr !== BASE) begin errors++; $display("FAIL single_awaddr: got=%h required=%h", m_axi_awaddr, BASE); end
        checks++; if (m_axi_wdata !== exp_w) begin errors++; $display("FAIL single_wdata: got=%h required=%h", m_axi_wdata, exp_w); end
        tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            errors++; $display("FAIL single_resp: aw/w/bready=%b required=001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        tick();
        checks++; if (words_written !== 32'd1) begin errors++; $display("FAIL single_count: got=%0d required=1", words_written); end
        checks++; if ({busy, m_axi_bready, wr_err} !== 3'b000) begin
            errors++; $display("FAIL single_done: busy/bready/err=%b required=000", {busy, m_axi_bready, wr_err}); end
        checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL single_pops: got=%0d required=1", rd_cnt - rd0); end
        checks++; if (m_axi_awaddr !== BASE + 32'd32) begin
            errors++; $display("FAIL single_next_addr: got=%h required=%h", m_axi_awaddr, BASE + 32'd32); end
        m_axi_bvalid = 1'b0;
    endtask

    task automatic test_w_before_aw();
        logic [WW-1:0] exp_w;
        exp_w = {8{32'h1234_5678}};
        m_axi_awready = 1'b0; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        push(exp_w);
        tick();
        tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin
            errors++; $display("FAIL wfirst_wdrop: aw/w=%b required=10", {m_axi_awvalid, m_axi_wvalid}); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({m_axi_awvalid, m_axi_bready, busy} !== 3'b101 || m_axi_awaddr !== BASE + 32'd32) begin
                errors++; $display("FAIL wfirst_hold%0d: aw/bready/busy=%b addr=%h required=101 %h",
                                   i, {m_axi_awvalid, m_axi_bready, busy}, m_axi_awaddr, BASE + 32'd32); end
        end
        m_axi_awready = 1'b1;
        tick();
        m_axi_awready = 1'b0;
        checks++; if ({m_axi_awvalid, m_axi_bready} !== 2'b01) begin
            errors++; $display("FAIL wfirst_toresp: aw/bready=%b required=01", {m_axi_awvalid, m_axi_bready}); end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        tick();
        checks++; if (words_written !== 32'd2 || m_axi_bready !== 1'b0) begin
            errors++; $display("FAIL wfirst_one_b: count=%0d bready=%b required=2 0", words_written, m_axi_bready); end
        checks++; if (m_axi_awaddr !== BASE) begin errors++; $display("FAIL wfirst_wrap: got=%h required=%h", m_axi_awaddr, BASE); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[3];
        logic [31:0] got_a[$];
        exp_a[0] = BASE; exp_a[1] = BASE + 32'd32; exp_a[2] = BASE;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        push({32{8'h11}}); push({32{8'h22}}); push({32{8'h33}});
        for (int i = 0; i < 9; i++) begin
            tick();
            if (m_axi_awvalid) got_a.push_back(m_axi_awaddr);
        end
        checks++; if (got_a.size() !== 3) begin errors++; $display("FAIL wrap_count: got=%0d addresses required=3", got_a.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got_a.size()) begin
                checks++; if (got_a[i] !== exp_a[i]) begin
                    errors++; $display("FAIL wrap_addr%0d: got=%h required=%h", i, got_a[i], exp_a[i]); end
            end
        end
        checks++; if (words_written !== 32'd5) begin errors++; $display("FAIL wrap_back_to_back: count=%0d required=5", words_written); end
        m_axi_bvalid = 1'b0;
    endtask

    task automatic test_error();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        push({32{8'h44}}); push({32{8'h55}}); push({32{8'h66}});
        for (int i = 0; i < 3; i++) tick();
        checks++; if (wr_err !== 1'b0 || words_written !== 32'd6) begin
            errors++; $display("FAIL err_first: err=%b count=%0d required=0 6", wr_err, words_written); end
        m_axi_bresp = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (wr_err !== 1'b1 || words_written !== 32'd7) begin
            errors++; $display("FAIL err_second: err=%b count=%0d required=1 7", wr_err, words_written); end
        m_axi_bresp = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (wr_err !== 1'b1 || words_written !== 32'd8) begin
            errors++; $display("FAIL err_sticky: err=%b count=%0d required=1 8", wr_err, words_written); end
        m_axi_bvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        push({32{8'h77}});
        for (int i = 0; i < 3; i++) tick();
        m_axi_bvalid = 1'b0;
        push({32{8'h88}});
        tick();
        tick();
        checks++; if (m_axi_bready !== 1'b1 || m_axi_awaddr !== BASE + 32'd32 || words_written !== 32'd9) begin
            errors++; $display("FAIL rstmid_pre: bready=%b addr=%h count=%0d required=1 %h 9",
                               m_axi_bready, m_axi_awaddr, BASE + 32'd32, words_written); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({m_axi_bready, busy, m_axi_awvalid, m_axi_wvalid, wr_err} !== 5'b0) begin
            errors++; $display("FAIL rstmid_flags: bready/busy/aw/w/err=%b required=00000",
                               {m_axi_bready, busy, m_axi_awvalid, m_axi_wvalid, wr_err}); end
        checks++; if (m_axi_awaddr !== BASE || words_written !== 32'd0) begin
            errors++; $display("FAIL rstmid_state: addr=%h count=%0d required=%h 0", m_axi_awaddr, words_written, BASE); end
    endtask

    initial begin
        rst = 1'b1;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        refresh();
        test_reset();
        test_single();
        test_w_before_aw();
        test_wrap();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
